// File: rtl/axil_reg_bank_if.sv
// Register read/write request interface between the AXI-lite adapters and the register bank.
interface axil_reg_bank_if #(
   parameter int unsigned ADDR_WIDTH = 40,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
   logic [ADDR_WIDTH-1:0] reg_wr_addr;
   logic [DATA_WIDTH-1:0] reg_wr_data;
   logic [STRB_WIDTH-1:0] reg_wr_strb;
   logic                  reg_wr_en;
   logic                  reg_wr_wait;
   logic                  reg_wr_ack;
   logic [ADDR_WIDTH-1:0] reg_rd_addr;
   logic                  reg_rd_en;
   logic [DATA_WIDTH-1:0] reg_rd_data;
   logic                  reg_rd_wait;
   logic                  reg_rd_ack;

   modport master (
      output reg_wr_addr, reg_wr_data, reg_wr_strb, reg_wr_en,
      output reg_rd_addr, reg_rd_en,
      input  reg_wr_wait, reg_wr_ack, reg_rd_data, reg_rd_wait, reg_rd_ack
   );

   modport slave (
      input  reg_wr_addr, reg_wr_data, reg_wr_strb, reg_wr_en,
      input  reg_rd_addr, reg_rd_en,
      output reg_wr_wait, reg_wr_ack, reg_rd_data, reg_rd_wait, reg_rd_ack
   );
endinterface

// File: rtl/axil_reg_bank.sv
// Control/status/cycle-counter/ID/config register bank for the accelerator core.
// Single-cycle read and write acks; reads return pre-write state when both hit together.
module axil_reg_bank #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 40,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned N_CFG      = 8,
   parameter logic [31:0] ID_VALUE   = 32'hC6A4_0001
) (
   input  logic                        clk,
   input  logic                        rstn,
   axil_reg_bank_if.slave              bus,
   input  logic                        core_busy,
   input  logic                        core_done,
   output logic                        core_start,
   output logic [N_CFG*DATA_WIDTH-1:0] cfg_regs,
   output logic                        irq
);

   localparam int unsigned IDX_W = $clog2(4 + N_CFG);

   typedef enum logic [1:0] {
      IDX_CTRL   = 2'd0,
      IDX_STATUS = 2'd1,
      IDX_CYCLES = 2'd2,
      IDX_ID     = 2'd3
   } fixed_idx_e;

   logic [IDX_W-1:0]      wr_idx;
   logic [IDX_W-1:0]      rd_idx;
   logic                  wr_fire;
   logic                  ctrl_wr;
   logic                  stat_wr;
   logic                  start_req;
   logic [DATA_WIDTH-1:0] rd_val;

   logic                  ien_q, ien_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  start_q, start_d;
   logic                  irq_q, irq_d;
   logic [DATA_WIDTH-1:0] cycles_q, cycles_d;
   logic [DATA_WIDTH-1:0] cfg_q [N_CFG];
   logic [DATA_WIDTH-1:0] cfg_d [N_CFG];
   logic                  rd_ack_q, rd_ack_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  wr_ack_q, wr_ack_d;

   // Word index only; byte offset and high address bits alias onto the map.
   assign wr_idx = bus.reg_wr_addr[2 +: IDX_W];
   assign rd_idx = bus.reg_rd_addr[2 +: IDX_W];

   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.reg_wr_addr[ADDR_WIDTH-1:IDX_W+2], bus.reg_wr_addr[1:0],
                               bus.reg_rd_addr[ADDR_WIDTH-1:IDX_W+2], bus.reg_rd_addr[1:0]};

   always_comb begin
      wr_fire   = bus.reg_wr_en && !wr_ack_q;
      ctrl_wr   = wr_fire && (wr_idx == IDX_W'(IDX_CTRL))   && bus.reg_wr_strb[0];
      stat_wr   = wr_fire && (wr_idx == IDX_W'(IDX_STATUS)) && bus.reg_wr_strb[0];
      start_req = ctrl_wr && bus.reg_wr_data[0];

      ien_d   = ctrl_wr ? bus.reg_wr_data[1] : ien_q;
      // Hardware set has priority over a coincident write-1-to-clear.
      done_d  = core_done | (done_q & ~(stat_wr & bus.reg_wr_data[1]));
      err_d   = (start_req & core_busy) | (err_q & ~(stat_wr & bus.reg_wr_data[2]));
      start_d = start_req & ~core_busy;
      irq_d   = done_q & ien_q;

      if (start_d) begin
         cycles_d = '0;
      end else if (core_busy && (cycles_q != '1)) begin
         cycles_d = cycles_q + DATA_WIDTH'(1);
      end else begin
         cycles_d = cycles_q;
      end

      for (int unsigned k = 0; k < N_CFG; k++) begin
         cfg_d[k] = cfg_q[k];
         if (wr_fire && (wr_idx == IDX_W'(4 + k))) begin
            for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
               if (bus.reg_wr_strb[b]) begin
                  cfg_d[k][8*b +: 8] = bus.reg_wr_data[8*b +: 8];
               end
            end
         end
      end

      rd_val = '0;
      case (rd_idx)
         IDX_W'(IDX_CTRL):   rd_val[1]   = ien_q;
         IDX_W'(IDX_STATUS): rd_val[2:0] = {err_q, done_q, core_busy};
         IDX_W'(IDX_CYCLES): rd_val      = cycles_q;
         IDX_W'(IDX_ID):     rd_val      = ID_VALUE;
         default: begin
            for (int unsigned k = 0; k < N_CFG; k++) begin
               if (rd_idx == IDX_W'(4 + k)) begin
                  rd_val = cfg_q[k];
               end
            end
         end
      endcase

      rd_ack_d  = bus.reg_rd_en && !rd_ack_q;
      rd_data_d = rd_ack_d ? rd_val : '0;
      wr_ack_d  = wr_fire;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ien_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         start_q   <= 1'b0;
         irq_q     <= 1'b0;
         cycles_q  <= '0;
         rd_ack_q  <= 1'b0;
         rd_data_q <= '0;
         wr_ack_q  <= 1'b0;
         for (int unsigned k = 0; k < N_CFG; k++) begin
            cfg_q[k] <= '0;
         end
      end else begin
         ien_q     <= ien_d;
         done_q    <= done_d;
         err_q     <= err_d;
         start_q   <= start_d;
         irq_q     <= irq_d;
         cycles_q  <= cycles_d;
         rd_ack_q  <= rd_ack_d;
         rd_data_q <= rd_data_d;
         wr_ack_q  <= wr_ack_d;
         for (int unsigned k = 0; k < N_CFG; k++) begin
            cfg_q[k] <= cfg_d[k];
         end
      end
   end

   assign bus.reg_wr_wait = 1'b0;
   assign bus.reg_rd_wait = 1'b0;
   assign bus.reg_wr_ack  = wr_ack_q;
   assign bus.reg_rd_ack  = rd_ack_q;
   assign bus.reg_rd_data = rd_data_q;
   assign core_start      = start_q;
   assign irq             = irq_q;

   for (genvar g = 0; g < N_CFG; g++) begin : g_cfg_out
      assign cfg_regs[g*DATA_WIDTH +: DATA_WIDTH] = cfg_q[g];
   end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank; read data is checked by a scoreboard monitor on rd_ack.
module tb_axil_reg_bank;

   localparam int unsigned N_CFG = 8;

   typedef struct {
      string       name;
      logic [31:0] data;
   } rd_exp_t;

   logic clk;
   logic rstn;
   logic core_busy;
   logic core_done;
   logic core_start;
   logic irq;
   logic [N_CFG*32-1:0] cfg_regs;
   logic [N_CFG*32-1:0] cfg_snap;

   int tests;
   int fails;
   int start_cnt;
   int s0;
   rd_exp_t exp_q[$];
   rd_exp_t mon_e;

   axil_reg_bank_if #(.ADDR_WIDTH(40), .DATA_WIDTH(32), .STRB_WIDTH(4)) bus ();

   axil_reg_bank #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(40),
      .STRB_WIDTH(4),
      .N_CFG     (N_CFG),
      .ID_VALUE  (32'hC6A4_0001)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .bus       (bus),
      .core_busy (core_busy),
      .core_done (core_done),
      .core_start(core_start),
      .cfg_regs  (cfg_regs),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every read ack must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rstn && bus.reg_rd_ack) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rd_spurious_ack: got ack with data 0x%08h, expected no ack", bus.reg_rd_data);
         end else begin
            mon_e = exp_q.pop_front();
            check(mon_e.name, bus.reg_rd_data, mon_e.data);
         end
      end
      if (core_start) start_cnt++;
   end

   task automatic rd(input string name, input logic [39:0] addr, input logic [31:0] exp);
      int lat;
      @(posedge clk); #1;
      exp_q.push_back('{name, exp});
      bus.reg_rd_addr = addr;
      bus.reg_rd_en   = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.reg_rd_ack && lat < 8);
      check({name, "_lat"}, 32'(lat), 32'd2);
      @(posedge clk); #1;
      bus.reg_rd_en = 1'b0;
      @(negedge clk);
      check({name, "_one_ack"}, {31'b0, bus.reg_rd_ack}, 32'd0);
   endtask

   task automatic wr(input string name, input logic [39:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input logic pulse_done);
      int lat;
      @(posedge clk); #1;
      bus.reg_wr_addr = addr;
      bus.reg_wr_data = data;
      bus.reg_wr_strb = strb;
      bus.reg_wr_en   = 1'b1;
      core_done       = pulse_done;
      @(posedge clk); #1;
      core_done = 1'b0;
      lat = 1;
      while (!bus.reg_wr_ack && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      check({name, "_wlat"}, 32'(lat), 32'd1);
      @(posedge clk); #1;
      bus.reg_wr_en = 1'b0;
      check({name, "_one_wack"}, {31'b0, bus.reg_wr_ack}, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tests = 0; fails = 0; start_cnt = 0;
      rstn = 1'b0; core_busy = 1'b0; core_done = 1'b0;
      bus.reg_wr_addr = '0; bus.reg_wr_data = '0; bus.reg_wr_strb = '0; bus.reg_wr_en = 1'b0;
      bus.reg_rd_addr = '0; bus.reg_rd_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_core_start", {31'b0, core_start}, 32'd0);
      check("rst_irq", {31'b0, irq}, 32'd0);
      check("rst_rd_ack", {31'b0, bus.reg_rd_ack}, 32'd0);
      check("rst_wr_ack", {31'b0, bus.reg_wr_ack}, 32'd0);
      check("rst_rd_data", bus.reg_rd_data, 32'd0);
      check("rst_cfg_zero", {31'b0, |cfg_regs}, 32'd0);
      rstn = 1'b1;

      // ID and address aliasing
      rd("rd_id", 40'h0C, 32'hC6A4_0001);
      rd("rd_id_alias_hi", 40'h4C, 32'hC6A4_0001);
      rd("rd_id_alias_lo", 40'h0E, 32'hC6A4_0001);

      // Byte-strobed CFG write
      wr("wr_cfg0", 40'h10, 32'hDEAD_BEEF, 4'b0101, 1'b0);
      check("cfg0_flat", cfg_regs[31:0], 32'h00AD_00EF);
      rd("rd_cfg0", 40'h10, 32'h00AD_00EF);

      // Start, count, done, irq, clear
      s0 = start_cnt;
      wr("wr_ctrl_start", 40'h00, 32'h3, 4'b0001, 1'b0);
      check("start_pulse_cnt", 32'(start_cnt - s0), 32'd1);
      rd("rd_cycles_0", 40'h08, 32'd0);
      rd("rd_ctrl_ien", 40'h00, 32'h2);
      @(posedge clk); #1; core_busy = 1'b1;
      repeat (10) @(posedge clk);
      #1; core_busy = 1'b0;
      rd("rd_cycles_10", 40'h08, 32'd10);
      @(posedge clk); #1; core_done = 1'b1;
      @(posedge clk); #1; core_done = 1'b0;
      @(posedge clk); #1;
      check("irq_set", {31'b0, irq}, 32'd1);
      rd("rd_status_done", 40'h04, 32'h2);
      wr("w1c_done", 40'h04, 32'h2, 4'b0001, 1'b0);
      check("irq_clear", {31'b0, irq}, 32'd0);
      rd("rd_status_clr", 40'h04, 32'h0);

      // Start while busy sets ERR without a pulse
      @(posedge clk); #1; core_busy = 1'b1;
      s0 = start_cnt;
      wr("wr_start_busy", 40'h00, 32'h1, 4'b0001, 1'b0);
      check("no_start_busy", 32'(start_cnt - s0), 32'd0);
      rd("rd_status_err", 40'h04, 32'h5);
      wr("w1c_err", 40'h04, 32'h4, 4'b0001, 1'b0);
      rd("rd_status_busy", 40'h04, 32'h1);
      @(posedge clk); #1; core_busy = 1'b0;

      // START ignored without byte-0 strobe
      s0 = start_cnt;
      wr("wr_ctrl_nostrb", 40'h00, 32'h3, 4'b1110, 1'b0);
      check("no_start_strb", 32'(start_cnt - s0), 32'd0);
      rd("rd_ctrl_nostrb", 40'h00, 32'h0);

      // core_done coinciding with W1C of DONE
      @(posedge clk); #1; core_done = 1'b1;
      @(posedge clk); #1; core_done = 1'b0;
      wr("w1c_done_collide", 40'h04, 32'h2, 4'b0001, 1'b1);
      rd("rd_done_kept", 40'h04, 32'h2);

      // Same-cycle read and write of CFG1
      wr("wr_cfg1", 40'h14, 32'h1122_3344, 4'b1111, 1'b0);
      @(posedge clk); #1;
      exp_q.push_back('{"rdwr_old_value", 32'h1122_3344});
      bus.reg_rd_addr = 40'h14; bus.reg_rd_en = 1'b1;
      bus.reg_wr_addr = 40'h14; bus.reg_wr_data = 32'hCAFE_F00D; bus.reg_wr_strb = 4'hF;
      bus.reg_wr_en = 1'b1;
      @(posedge clk); #1;
      check("rdwr_rd_ack", {31'b0, bus.reg_rd_ack}, 32'd1);
      check("rdwr_wr_ack", {31'b0, bus.reg_wr_ack}, 32'd1);
      @(posedge clk); #1;
      bus.reg_rd_en = 1'b0; bus.reg_wr_en = 1'b0;
      check("cfg1_flat", cfg_regs[63:32], 32'hCAFE_F00D);
      rd("rd_cfg1_new", 40'h14, 32'hCAFE_F00D);

      // Out-of-range index
      cfg_snap = cfg_regs;
      wr("wr_oor", 40'h3C, 32'hFFFF_FFFF, 4'hF, 1'b0);
      check("oor_cfg_unchanged", {31'b0, cfg_regs == cfg_snap}, 32'd1);
      check("oor_cfg7", cfg_regs[255:224], 32'd0);
      rd("rd_oor_15", 40'h3C, 32'h0);
      rd("rd_oor_12", 40'h30, 32'h0);
      rd("rd_ctrl_after_oor", 40'h00, 32'h0);

      // Reset during an outstanding read
      @(posedge clk); #1;
      bus.reg_rd_addr = 40'h10; bus.reg_rd_en = 1'b1; rstn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_mid_no_ack", {31'b0, bus.reg_rd_ack}, 32'd0);
      end
      @(posedge clk); #1; bus.reg_rd_en = 1'b0;
      @(posedge clk); #1; rstn = 1'b1;
      check("rst_mid_cfg_zero", {31'b0, |cfg_regs}, 32'd0);
      rd("rd_cfg0_after_rst", 40'h10, 32'h0);
      rd("rd_cfg1_after_rst", 40'h14, 32'h0);
      rd("rd_status_after_rst", 40'h04, 32'h0);

      repeat (3) @(posedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/axil_reg_bank.md
Name: axil_reg_bank

Overview:
- Register bank that terminates the register read/write interfaces produced by the AXI-lite read and write adapters.
- Holds the control, status, cycle-counter, ID and generic configuration registers for the accelerator core.
- Drives the core start pulse and the interrupt line, and exposes the configuration registers to the datapath as a flat bus.

Parameters:
DATA_WIDTH, 32, register and data bus width; fixed at 32 in this revision.
ADDR_WIDTH, 40, byte address width of the register interface.
STRB_WIDTH, DATA_WIDTH/8, byte strobe width.
N_CFG, 8, number of generic RW config registers; must be at least 1.
ID_VALUE, 32'hC6A4_0001, constant returned by the ID register.
IDX_W, $clog2(4+N_CFG), localparam; word-index width.

Ports:
clk  in  1  clock
rstn  in  1  reset; synchronous, active-low
reg_wr_addr  in  ADDR_WIDTH  write byte address
reg_wr_data  in  DATA_WIDTH  write data
reg_wr_strb  in  STRB_WIDTH  write byte enables
reg_wr_en  in  1  write request; held high until acknowledged
reg_wr_wait  out  1  write wait; constant 0
reg_wr_ack  out  1  write acknowledge; one-cycle pulse
reg_rd_addr  in  ADDR_WIDTH  read byte address
reg_rd_en  in  1  read request; held high until acknowledged
reg_rd_data  out  DATA_WIDTH  read data; valid while reg_rd_ack=1
reg_rd_wait  out  1  read wait; constant 0
reg_rd_ack  out  1  read acknowledge; one-cycle pulse
core_busy  in  1  core running (level)
core_done  in  1  core completion (one-cycle pulse)
core_start  out  1  start pulse to core; one cycle
cfg_regs  out  N_CFG*DATA_WIDTH  flat config registers; CFG k at bits [k*32 +: 32]
irq  out  1  interrupt, level, registered

Behaviour:
- Decode: word index = addr[2 +: IDX_W]. Address bits [1:0] and bits above IDX_W+2 are ignored, so the map aliases.
- Register map, by word index:
  - 0 CTRL: bit0 START is write-1-to-pulse and reads 0. bit1 IEN is RW. Other bits read 0.
  - 1 STATUS: bit0 BUSY is live core_busy. bit1 DONE is sticky, W1C. bit2 ERR is sticky, W1C. Other bits read 0.
  - 2 CYCLES: RO.
  - 3 ID: RO, returns ID_VALUE.
  - 4..3+N_CFG CFG: RW, byte-strobed.
  - Any other index: reads 0; writes are dropped but still acknowledged.
- Reset: all CFG registers, IEN, DONE, ERR and CYCLES clear to 0. reg_rd_ack, reg_wr_ack, reg_rd_data, core_start and irq reset to 0.
- Read handshake:
  - rd_ack_next = reg_rd_en && !reg_rd_ack, so the ack pulses exactly once per request, one cycle after en rises.
  - reg_rd_data is registered in the same cycle as the ack and is 0 when no ack is pending.
  - The requester may keep en high during the ack cycle; no second ack may follow.
  - Read latency is one cycle. Reads have no side effects.
- Write handshake:
  - Commit happens in the cycle where reg_wr_en && !reg_wr_ack.
  - reg_wr_ack pulses in the next cycle.
  - A write is committed exactly once per request.
- Byte strobes: only enabled bytes update. For CTRL, START acts only if strobe[0]=1 and data bit0=1. W1C bits clear only if their byte strobe is set.
- START:
  - If core_busy=0 when START is committed, core_start=1 on the next cycle (one-cycle pulse) and CYCLES clears to 0 in that same cycle.
  - If core_busy=1, no pulse is issued and ERR is set.
- CYCLES: increments by 1 on every cycle with core_busy=1. It saturates at 32'hFFFF_FFFF; no wrap-around.
- DONE: set on core_done. If core_done coincides with a W1C of DONE, set wins and DONE stays 1.
- ERR: if a start-while-busy coincides with a W1C of ERR, set wins.
- irq: registered value of (DONE && IEN). It deasserts one cycle after DONE is cleared or IEN is written 0.
- Simultaneous read and write in the same cycle:
  - Both are served independently.
  - The read returns the pre-write value.
  - Both acks pulse in the same cycle.
- Reset mid-transaction: pending acks are dropped and all state returns to reset values. The upstream adapter's timeout recovers the read.

Test Plan:
- Read ID: rd_en=1 at index 3 -> rd_ack exactly one cycle later with data 32'hC6A4_0001. en held for 2 cycles still yields only one ack.
- Write CFG: write 0xDEADBEEF with strb 4'b0101 to CFG0 (byte addr 0x10) -> cfg_regs[31:0]=0x00AD00EF. Read back returns the same value.
- Start/done flow:
  - Write CTRL=0x3 with core_busy=0 -> core_start high for one cycle and CYCLES=0.
  - Hold busy 10 cycles -> CYCLES reads 10.
  - Pulse core_done -> STATUS DONE=1, irq=1.
  - Write STATUS=0x2 -> DONE=0, irq=0 one cycle later.
- Start while busy: core_busy=1, write CTRL=0x1 -> no core_start pulse and STATUS reads 0x5. W1C 0x4 -> STATUS reads 0x1.
- Collisions:
  - core_done in the same cycle as a W1C of DONE -> DONE remains 1.
  - Read and write of CFG1 in the same cycle -> read returns the old value and the new value is stored.
- Out-of-range and reset:
  - Write index 15 with N_CFG=8 -> acked and no register changes; a read there returns 0.
  - Assert rstn=0 mid-read -> no ack, and all CFG registers read 0 after reset.
